keypad_scan_controller: RTL and testbench

//   Sequences a 4x4 matrix keypad: drives one column low at a time and reads row pins through an internal 2-FF synchronizer.

---
 rtl/keypad_scan_controller.sv | 170 +++++++++++++++++
 tb/tb_keypad_scan_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner with row synchronizer and press/release debounce.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_controller #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned MAX_CNT = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {SCAN, PRESS, HELD, RELEASE} state_t;

  state_t           state;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [3:0]       cap_row;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       row_dec;
  logic [3:0]       sync1;
  logic [3:0]       sense;
  logic             sense_match;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
`endif

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Exactly one low row maps to a one-hot row; anything else (none or several) is no key.
  always_comb begin
    row_dec = 4'b0000;
    case (rows)
      4'b0111: row_dec = 4'b1000;
      4'b1011: row_dec = 4'b0100;
      4'b1101: row_dec = 4'b0010;
      4'b1110: row_dec = 4'b0001;
      default: row_dec = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 4'b0000;
      sense <= 4'b0000;
    end else begin
      sync1 <= row_dec;
      sense <= sync1;
    end
  end

  assign sense_match = (sense == cap_row);

  // Scan / debounce state machine; every output is a register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cols      <= 4'b1110;
      row_idx   <= 2'd0;
      cap_row   <= 4'b0000;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if ($onehot(sense)) begin
              cap_row <= sense;
              row_idx <= onehot_idx(sense);
              state   <= PRESS;
            end else begin
              col_idx <= col_idx + 2'd1;
              cols    <= col_drive(col_idx + 2'd1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESS: begin
          if (!sense_match) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            cols    <= col_drive(col_idx + 2'd1);
            state   <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt       <= '0;
            key_code  <= {row_idx, col_idx};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HELD: begin
          if (!sense_match) begin
            cnt   <= '0;
            state <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt   <= '0;
            key_valid <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + CNT_W'(1);
`endif
          end
        end

        RELEASE: begin
          if (sense_match) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            cols     <= col_drive(col_idx + 2'd1);
            state    <= SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Directed bench for keypad_scan_controller with a behavioural 4x4 key matrix.
module tb_keypad_scan_controller;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keymat;   // bit row*4+col = key pressed
  int n_cmp;
  int n_fail;
  int pulse_cnt;

  keypad_scan_controller #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++)
      rows[r] = ~|(keymat[r*4 +: 4] & ~cols);
  end

  always @(negedge clk) if (key_valid) pulse_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_code;
    logic [3:0] exp_cols;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (key_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_release(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (!key_held) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int p0;
    int changes;
    int exp_rep;
    logic [3:0] prev_cols;
    logic [3:0] exp_c;

    n_cmp = 0; n_fail = 0; pulse_cnt = 0;
    keymat = 16'h0000;
    reset  = 1'b0;

    vecs[0] = '{2, 2, 4'hA, 4'b1011};
    vecs[1] = '{1, 2, 4'h6, 4'b1011};
    vecs[2] = '{0, 1, 4'h1, 4'b1101};
    vecs[3] = '{3, 3, 4'hF, 4'b0111};
    vecs[4] = '{0, 0, 4'h0, 4'b1110};
    vecs[5] = '{3, 0, 4'hC, 4'b1110};
    vecs[6] = '{2, 1, 4'h9, 4'b1101};

    // Reset values, then free-running column scan with no key
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cols", 32'(cols), 32'(4'b1110));
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_c = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("scan_cols_%0d", k), 32'(cols), 32'(exp_c));
    end
    check("scan_no_valid", 32'(pulse_cnt), 32'h0);

    // Table of single clean presses
    foreach (vecs[v]) begin
      keymat = 16'h0000;
      keymat[vecs[v].row*4 + vecs[v].col] = 1'b1;
      wait_valid(200, cyc);
      check($sformatf("vec%0d_seen", v), 32'(cyc > 0), 32'h1);
      check($sformatf("vec%0d_latency_min", v), 32'(cyc >= 11), 32'h1);
      check($sformatf("vec%0d_code", v), 32'(key_code), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d_held", v), 32'(key_held), 32'h1);
      @(negedge clk);
      check($sformatf("vec%0d_one_cycle", v), 32'(key_valid), 32'h0);
      p0 = pulse_cnt;
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_cols_frozen", v), 32'(cols), 32'(vecs[v].exp_cols));
      check($sformatf("vec%0d_no_extra", v), 32'(pulse_cnt), 32'(p0));
      keymat = 16'h0000;
      wait_release(100, cyc);
      check($sformatf("vec%0d_release", v), 32'(cyc > 0), 32'h1);
      check($sformatf("vec%0d_code_kept", v), 32'(key_code), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d_no_rel_pulse", v), 32'(pulse_cnt), 32'(p0));
      repeat (5) @(negedge clk);
    end

    // Bouncing press on row0/col1: 3 on, 1 off, never 8 stable cycles
    p0 = pulse_cnt;
    repeat (8) begin
      keymat = 16'h0002;
      repeat (3) @(negedge clk);
      keymat = 16'h0000;
      @(negedge clk);
    end
    check("bounce_no_valid", 32'(pulse_cnt), 32'(p0));
    keymat = 16'h0002;
    wait_valid(200, cyc);
    check("bounce_seen", 32'(cyc > 0), 32'h1);
    check("bounce_code", 32'(key_code), 32'h1);
    @(negedge clk);
    p0 = pulse_cnt;
    repeat (6) @(negedge clk);
    check("bounce_single", 32'(pulse_cnt), 32'(p0));
    keymat = 16'h0000;
    wait_release(100, cyc);
    check("bounce_release", 32'(cyc > 0), 32'h1);
    repeat (3) @(negedge clk);

    // Two rows low on column 3 (rows=1001) is never accepted
    p0 = pulse_cnt;
    keymat = 16'h0000;
    keymat[7]  = 1'b1;
    keymat[11] = 1'b1;
    changes = 0;
    prev_cols = cols;
    repeat (50) begin
      @(negedge clk);
      if (cols != prev_cols) changes++;
      prev_cols = cols;
    end
    check("multirow_no_valid", 32'(pulse_cnt), 32'(p0));
    check("multirow_scanning", 32'(changes >= 10), 32'h1);
    check("multirow_not_held", 32'(key_held), 32'h0);
    keymat = 16'h0000;
    repeat (3) @(negedge clk);

    // Short release inside debounce window, then real release, then fresh press
    keymat = 16'h0040;
    wait_valid(200, cyc);
    check("repress_first_code", 32'(key_code), 32'h6);
    @(negedge clk);
    p0 = pulse_cnt;
    keymat = 16'h0000;
    repeat (5) @(negedge clk);
    keymat = 16'h0040;
    repeat (10) @(negedge clk);
    check("repress_still_held", 32'(key_held), 32'h1);
    check("repress_no_pulse", 32'(pulse_cnt), 32'(p0));
    keymat = 16'h0000;
    repeat (20) @(negedge clk);
    check("repress_held_fell", 32'(key_held), 32'h0);
    check("repress_no_rel_pulse", 32'(pulse_cnt), 32'(p0));
    keymat = 16'h0040;
    wait_valid(200, cyc);
    check("repress_fresh_seen", 32'(cyc > 0), 32'h1);
    check("repress_fresh_code", 32'(key_code), 32'h6);
    @(negedge clk);
    keymat = 16'h0000;
    wait_release(100, cyc);
    check("repress_fresh_release", 32'(cyc > 0), 32'h1);
    repeat (3) @(negedge clk);

    // Long hold of key F: auto-repeat count depends on build
`ifdef KEYPAD_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 0;
`endif
    keymat = 16'h8000;
    wait_valid(200, cyc);
    check("hold_code", 32'(key_code), 32'hF);
    @(negedge clk);
    p0 = pulse_cnt;
    repeat (69) @(negedge clk);
    check("hold_repeat_pulses", 32'(pulse_cnt - p0), 32'(exp_rep));
    check("hold_code_kept", 32'(key_code), 32'hF);

    // Reset while HELD
    reset = 1'b0;
    @(negedge clk);
    check("midrst_cols", 32'(cols), 32'(4'b1110));
    check("midrst_held", 32'(key_held), 32'h0);
    check("midrst_code", 32'(key_code), 32'h0);
    check("midrst_valid", 32'(key_valid), 32'h0);
    keymat = 16'h0000;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_scan", 32'(cols), 32'(4'b1101));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
